// File: rtl/pe_group_sequencer_pkg.sv
// Shared types and derived-size helpers for the PE_Group sequencer.
package pe_group_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  function automatic int calcISize(input int wSize, input int oSize);
    return wSize + oSize - 1;
  endfunction

  // Per-stream counters hold tiles*groupSize; +3 bits covers group sizes up to 8.
  function automatic int calcCntWidth(input int tileCountWidth);
    return tileCountWidth + 3;
  endfunction

endpackage

// File: rtl/pe_group_sequencer_fetch.sv
// One buffer-to-PE_Group stream: read issue counter, one in-flight read, 2-entry FIFO.
module seq_stream_fetch
  import pe_group_sequencer_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 8,
  parameter int CntWidth  = 11
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 clkEn,
  input  logic                 run,
  input  logic [AddrWidth-1:0] base,
  input  logic [CntWidth-1:0]  total,
  output logic                 rdEn,
  output logic [AddrWidth-1:0] rdAddr,
  input  logic [DataWidth-1:0] rdData,
  output logic                 valid,
  input  logic                 rdy,
  output logic [DataWidth-1:0] data,
  output logic                 drained
);

  logic [CntWidth-1:0]  issueCnt;
  logic                 inflight;
  logic [DataWidth-1:0] fifoMem [2];
  logic                 rdPtr;
  logic                 wrPtr;
  logic [1:0]           fifoCnt;
  logic                 push;
  logic                 pop;
  logic [1:0]           occupancy;

  assign valid  = (fifoCnt != 2'd0);
  assign data   = fifoMem[rdPtr];
  assign push   = clkEn & inflight;
  assign pop    = clkEn & valid & rdy;
  assign rdAddr = base + AddrWidth'(issueCnt);

  // Crediting the same-cycle pop lets a full pipe keep issuing one read per cycle.
  assign occupancy = fifoCnt + {1'b0, inflight} - {1'b0, pop};
  assign rdEn      = clkEn & run & (issueCnt < total) & (occupancy < 2'd2);

  assign drained = (issueCnt == total) & ~inflight & ~valid;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      issueCnt   <= '0;
      inflight   <= 1'b0;
      rdPtr      <= 1'b0;
      wrPtr      <= 1'b0;
      fifoCnt    <= 2'd0;
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
    end else if (clkEn) begin
      inflight <= rdEn;
      if (!run) begin
        issueCnt <= '0;
      end else if (rdEn) begin
        issueCnt <= issueCnt + CntWidth'(1);
      end
      if (push) begin
        fifoMem[wrPtr] <= rdData;
        wrPtr          <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      fifoCnt <= fifoCnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/pe_group_sequencer.sv
// Command-driven tile scheduler feeding one PE_Group from W/I/O buffers and writing results back.
// state | meaning
// IDLE  | waiting for a command, cmd_rdy high
// RUN   | streaming tiles into PE_Group and collecting results
// DONE  | command finished; done pulses as the FSM returns to IDLE
module pe_group_sequencer
  import pe_group_sequencer_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int W_PEGroupSize  = 3,
  parameter int O_PEGroupSize  = 4,
  parameter int I_PEGroupSize  = calcISize(W_PEGroupSize, O_PEGroupSize),
  parameter int AddrWidth      = 8,
  parameter int TileCountWidth = 8,
  parameter int CntWidth       = calcCntWidth(TileCountWidth)
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      clk_en,
  input  logic                      cmd_valid,
  output logic                      cmd_rdy,
  input  logic [AddrWidth-1:0]      cmd_w_base,
  input  logic [AddrWidth-1:0]      cmd_i_base,
  input  logic [AddrWidth-1:0]      cmd_o_base,
  input  logic [AddrWidth-1:0]      cmd_r_base,
  input  logic [TileCountWidth-1:0] cmd_tiles,
  output logic                      done,
  output logic                      w_rd_en,
  output logic                      i_rd_en,
  output logic                      o_rd_en,
  output logic [AddrWidth-1:0]      w_rd_addr,
  output logic [AddrWidth-1:0]      i_rd_addr,
  output logic [AddrWidth-1:0]      o_rd_addr,
  input  logic [DataWidth-1:0]      w_rd_data,
  input  logic [DataWidth-1:0]      i_rd_data,
  input  logic [DataWidth-1:0]      o_rd_data,
  output logic                      r_wr_en,
  output logic [AddrWidth-1:0]      r_wr_addr,
  output logic [DataWidth-1:0]      r_wr_data,
  output logic                      W_Valid,
  output logic                      I_Valid,
  output logic                      O_Valid,
  input  logic                      W_Rdy,
  input  logic                      I_Rdy,
  input  logic                      O_Rdy,
  output logic [DataWidth-1:0]      W_Data,
  output logic [DataWidth-1:0]      I_Data,
  output logic [DataWidth-1:0]      O_Data,
  input  logic                      R_Valid,
  output logic                      R_Rdy,
  input  logic [DataWidth-1:0]      R_Data
);

  localparam logic [CntWidth-1:0] WSize = CntWidth'(W_PEGroupSize);
  localparam logic [CntWidth-1:0] ISize = CntWidth'(I_PEGroupSize);
  localparam logic [CntWidth-1:0] OSize = CntWidth'(O_PEGroupSize);

  seqState_t            state;
  logic [AddrWidth-1:0] wBase;
  logic [AddrWidth-1:0] iBase;
  logic [AddrWidth-1:0] oBase;
  logic [AddrWidth-1:0] rBase;
  logic [CntWidth-1:0]  totW;
  logic [CntWidth-1:0]  totI;
  logic [CntWidth-1:0]  totO;
  logic [CntWidth-1:0]  resCnt;
  logic                 doneReg;
  logic                 run;
  logic                 resHs;
  logic                 wDrained;
  logic                 iDrained;
  logic                 oDrained;

  assign run     = (state == RUN);
  assign cmd_rdy = (state == IDLE);
  assign done    = doneReg & clk_en;

  assign R_Rdy     = run & (resCnt < totO);
  assign resHs     = clk_en & R_Valid & R_Rdy;
  assign r_wr_en   = resHs;
  assign r_wr_addr = rBase + AddrWidth'(resCnt);
  assign r_wr_data = R_Data;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state   <= IDLE;
      wBase   <= '0;
      iBase   <= '0;
      oBase   <= '0;
      rBase   <= '0;
      totW    <= '0;
      totI    <= '0;
      totO    <= '0;
      resCnt  <= '0;
      doneReg <= 1'b0;
    end else if (clk_en) begin
      doneReg <= 1'b0;
      if (resHs) begin
        resCnt <= resCnt + CntWidth'(1);
      end
      unique case (state)
        IDLE: begin
          resCnt <= '0;
          if (cmd_valid) begin
            wBase <= cmd_w_base;
            iBase <= cmd_i_base;
            oBase <= cmd_o_base;
            rBase <= cmd_r_base;
            totW  <= CntWidth'(cmd_tiles) * WSize;
            totI  <= CntWidth'(cmd_tiles) * ISize;
            totO  <= CntWidth'(cmd_tiles) * OSize;
            state <= (cmd_tiles == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (wDrained && iDrained && oDrained && (resCnt == totO)) begin
            state <= DONE;
          end
        end
        DONE: begin
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_stream_fetch #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth),
    .CntWidth (CntWidth)
  ) uWFetch (
    .clk    (clk),
    .aclr   (aclr),
    .clkEn  (clk_en),
    .run    (run),
    .base   (wBase),
    .total  (totW),
    .rdEn   (w_rd_en),
    .rdAddr (w_rd_addr),
    .rdData (w_rd_data),
    .valid  (W_Valid),
    .rdy    (W_Rdy),
    .data   (W_Data),
    .drained(wDrained)
  );

  seq_stream_fetch #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth),
    .CntWidth (CntWidth)
  ) uIFetch (
    .clk    (clk),
    .aclr   (aclr),
    .clkEn  (clk_en),
    .run    (run),
    .base   (iBase),
    .total  (totI),
    .rdEn   (i_rd_en),
    .rdAddr (i_rd_addr),
    .rdData (i_rd_data),
    .valid  (I_Valid),
    .rdy    (I_Rdy),
    .data   (I_Data),
    .drained(iDrained)
  );

  seq_stream_fetch #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth),
    .CntWidth (CntWidth)
  ) uOFetch (
    .clk    (clk),
    .aclr   (aclr),
    .clkEn  (clk_en),
    .run    (run),
    .base   (oBase),
    .total  (totO),
    .rdEn   (o_rd_en),
    .rdAddr (o_rd_addr),
    .rdData (o_rd_data),
    .valid  (O_Valid),
    .rdy    (O_Rdy),
    .data   (O_Data),
    .drained(oDrained)
  );

endmodule
